pipe_field: RTL and testbench

- Parametrised obstacle engine; successor to the fixed three-pipe logic inside the game controller.
- Holds N_PIPES pipes in a ring of slots. Each valid pipe scrolls toward the bird once per frame.
- Spawns new pipes on a frame period, with the gap position taken from the random source.
- Detects bird/pipe and ground collisions and keeps a DIGITS-digit BCD score with saturation. The game FSM drives run/clear; renderers consume the flattened pipe outputs.

---
 rtl/pipe_field_if.sv | 33 +++
 rtl/pipe_field.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_field.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_field_if.sv
// pipe_field_if: game-side bundle for the pipe obstacle engine.
// The game FSM / renderers sit on the master side, the engine on the slave side.
interface pipe_field_if #(
  parameter int N_PIPES = 3,
  parameter int DIGITS  = 2
);
  logic                      new_frame;
  logic                      run;
  logic                      clear;
  logic [7:0]                rand_in;
  logic signed [15:0]        bird_scroll;
  logic signed [15:0]        bird_gap;
  logic [16*N_PIPES-1:0]     pipe_scroll;
  logic [16*N_PIPES-1:0]     pipe_gap;
  logic [N_PIPES-1:0]        pipe_valid;
  logic                      hit;
  logic                      score_pulse;
  logic [4*DIGITS-1:0]       score_bcd;
  logic                      score_sat;
  logic                      spawn_drop;

  modport master (
    output new_frame, run, clear, rand_in, bird_scroll, bird_gap,
    input  pipe_scroll, pipe_gap, pipe_valid, hit, score_pulse,
           score_bcd, score_sat, spawn_drop
  );

  modport slave (
    input  new_frame, run, clear, rand_in, bird_scroll, bird_gap,
    output pipe_scroll, pipe_gap, pipe_valid, hit, score_pulse,
           score_bcd, score_sat, spawn_drop
  );
endinterface

// File: rtl/pipe_field.sv
// pipe_field: ring of scrolling pipe slots with periodic spawn, off-screen
// retirement, BCD scoring with saturation and bird/pipe/ground collision.
module pipe_field #(
  parameter int N_PIPES      = 3,
  parameter int SPEED        = 5,
  parameter int SPAWN_PERIOD = 64,
  parameter int SPAWN_POS    = 640,
  parameter int OFFSCREEN    = -120,
  parameter int GAP_BASE     = 100,
  parameter int GAP_H        = 150,
  parameter int PIPE_W       = 96,
  parameter int BIRD_W       = 40,
  parameter int BIRD_H       = 40,
  parameter int GROUND       = 104,
  parameter int DIGITS       = 2
) (
  input logic         clk,
  input logic         rstn,
  pipe_field_if.slave bus
);

  localparam int PTR_W = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_PIPES - 1);
  localparam logic [CNT_W-1:0]   CNT_RELOAD = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic signed [15:0] OFFS_LIM   = 16'(OFFSCREEN);
  localparam logic signed [15:0] GROUND_LIM = 16'(GROUND);
  localparam logic signed [15:0] SPEED16    = 16'(SPEED);
  localparam logic signed [15:0] SPAWN16    = 16'(SPAWN_POS);
  localparam logic [15:0]        GAP_BASE16 = 16'(GAP_BASE);
  localparam logic signed [16:0] PIPE_W17   = 17'(PIPE_W);
  localparam logic signed [16:0] BIRD_W17   = 17'(BIRD_W);
  localparam logic signed [16:0] BIRD_H17   = 17'(BIRD_H);
  localparam logic signed [16:0] GAP_H17    = 17'(GAP_H);

  // slot state
  logic signed [15:0]  scroll_q [N_PIPES];
  logic signed [15:0]  gap_q    [N_PIPES];
  logic [N_PIPES-1:0]  valid_q;
  logic [N_PIPES-1:0]  scored_q;

  // control state; spawn_cnt_q holds frames remaining until the next spawn
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    spawn_cnt_q;
  logic [4*DIGITS-1:0] score_q;
  logic                hit_q;
  logic                pulse_q;
  logic                drop_q;

  // next-state helpers
  logic                frame_en;
  logic signed [15:0]  scroll_dec [N_PIPES];
  logic [N_PIPES-1:0]  retiring;
  logic [N_PIPES-1:0]  score_sel;
  logic                score_seen;
  logic                score_any;
  logic                spawn_now;
  logic                spawn_ok;
  logic [N_PIPES-1:0]  spawn_load;
  logic signed [15:0]  gap_new;
  logic [4*DIGITS-1:0] score_inc;
  logic                score_full;
  logic                bcd_carry;
  logic                coll_any;
  logic signed [16:0]  bird_s17;
  logic signed [16:0]  bird_g17;
  logic [16*N_PIPES-1:0] scroll_flat;
  logic [16*N_PIPES-1:0] gap_flat;

  assign frame_en  = bus.new_frame & bus.run;
  assign bird_s17  = 17'(bus.bird_scroll);
  assign bird_g17  = 17'(bus.bird_gap);
  assign gap_new   = GAP_BASE16 + {8'd0, bus.rand_in};
  assign spawn_now = frame_en && (spawn_cnt_q == '0);
  // a slot whose pipe leaves the screen this frame is free for the spawn
  assign spawn_ok  = !valid_q[wr_ptr_q] || retiring[wr_ptr_q];
  assign score_any = |score_sel;

  // per-slot scroll/retire decode and lowest-index score candidate
  always_comb begin
    score_seen = 1'b0;
    for (int i = 0; i < N_PIPES; i++) begin
      scroll_dec[i] = scroll_q[i] - SPEED16;
      retiring[i]   = valid_q[i] && (scroll_dec[i] < OFFS_LIM);
      score_sel[i]  = 1'b0;
      if (valid_q[i] && !scored_q[i] && ((17'(scroll_q[i]) + PIPE_W17) < bird_s17)) begin
        score_sel[i] = !score_seen;
        score_seen   = 1'b1;
      end
      spawn_load[i] = spawn_now && spawn_ok && (wr_ptr_q == PTR_W'(i));
    end
  end

  // BCD increment with ripple carry and all-nines detect
  always_comb begin
    score_inc  = score_q;
    score_full = 1'b1;
    bcd_carry  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (score_q[4*d +: 4] != 4'd9) score_full = 1'b0;
      if (bcd_carry) begin
        if (score_q[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_q[4*d +: 4] + 4'd1;
          bcd_carry = 1'b0;
        end
      end
    end
  end

  // bird overlap against every valid pipe outside its gap, plus ground
  always_comb begin
    coll_any = (bus.bird_gap <= GROUND_LIM);
    for (int i = 0; i < N_PIPES; i++) begin
      if (valid_q[i]
          && ((bird_s17 + BIRD_W17) > 17'(scroll_q[i]))
          && (bird_s17 < (17'(scroll_q[i]) + PIPE_W17))
          && ((bird_g17 < 17'(gap_q[i]))
              || ((bird_g17 + BIRD_H17) > (17'(gap_q[i]) + GAP_H17))))
        coll_any = 1'b1;
    end
  end

  // slot ring: spawn load wins over scroll; retire and score flags ride along
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_PIPES; i++) begin
        scroll_q[i] <= '0;
        gap_q[i]    <= '0;
      end
      valid_q  <= '0;
      scored_q <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < N_PIPES; i++) begin
        scroll_q[i] <= '0;
        gap_q[i]    <= '0;
      end
      valid_q  <= '0;
      scored_q <= '0;
    end else if (frame_en) begin
      for (int i = 0; i < N_PIPES; i++) begin
        if (spawn_load[i]) begin
          scroll_q[i] <= SPAWN16;
          gap_q[i]    <= gap_new;
          valid_q[i]  <= 1'b1;
          scored_q[i] <= 1'b0;
        end else if (valid_q[i]) begin
          scroll_q[i] <= scroll_dec[i];
          if (retiring[i])  valid_q[i]  <= 1'b0;
          if (score_sel[i]) scored_q[i] <= 1'b1;
        end
      end
    end
  end

  // spawn timer, write pointer, score, drop flag and registered hit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      spawn_cnt_q <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      pulse_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_q    <= '0;
      spawn_cnt_q <= '0;
      score_q     <= '0;
      hit_q       <= 1'b0;
      pulse_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      hit_q   <= coll_any;
      pulse_q <= 1'b0;
      if (frame_en) begin
        if (spawn_cnt_q == '0) spawn_cnt_q <= CNT_RELOAD;
        else                   spawn_cnt_q <= spawn_cnt_q - 1'b1;
        if (spawn_now) begin
          if (spawn_ok) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
          else          drop_q   <= 1'b1;
        end
        if (score_any && !score_full) begin
          score_q <= score_inc;
          pulse_q <= 1'b1;
        end
      end
    end
  end

  // flatten slot registers onto the renderer buses
  always_comb begin
    scroll_flat = '0;
    gap_flat    = '0;
    for (int i = 0; i < N_PIPES; i++) begin
      scroll_flat[16*i +: 16] = scroll_q[i];
      gap_flat[16*i +: 16]    = gap_q[i];
    end
  end

  assign bus.pipe_scroll = scroll_flat;
  assign bus.pipe_gap    = gap_flat;
  assign bus.pipe_valid  = valid_q;
  assign bus.hit         = hit_q;
  assign bus.score_pulse = pulse_q;
  assign bus.score_bcd   = score_q;
  assign bus.score_sat   = score_full;
  assign bus.spawn_drop  = drop_q;

endmodule

// File: tb/tb_pipe_field.sv
// tb_pipe_field: directed and randomized checks of pipe_field against an
// integer-arithmetic model of the obstacle rules.
module tb_pipe_field;
  localparam int N      = 3;
  localparam int SPEED  = 5;
  localparam int PERIOD = 64;
  localparam int SPOS   = 640;
  localparam int OFFS   = -120;
  localparam int GBASE  = 100;
  localparam int GH     = 150;
  localparam int PW     = 96;
  localparam int BW     = 40;
  localparam int BH     = 40;
  localparam int GRND   = 104;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pipe_field_if #(.N_PIPES(3), .DIGITS(2)) bus ();
  pipe_field_if #(.N_PIPES(2), .DIGITS(2)) bus2 ();

  pipe_field #(
    .N_PIPES(3), .SPEED(SPEED), .SPAWN_PERIOD(PERIOD), .SPAWN_POS(SPOS),
    .OFFSCREEN(OFFS), .GAP_BASE(GBASE), .GAP_H(GH), .PIPE_W(PW),
    .BIRD_W(BW), .BIRD_H(BH), .GROUND(GRND), .DIGITS(2)
  ) dut (.clk(clk), .rstn(rstn), .bus(bus));

  pipe_field #(
    .N_PIPES(2), .SPAWN_PERIOD(2), .OFFSCREEN(-30000), .DIGITS(2)
  ) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  int n_pass   = 0;
  int n_checks = 0;

  // reference model state
  int m_scroll [N];
  int m_gap    [N];
  bit m_valid  [N];
  bit m_scored [N];
  int m_wr, m_cnt, m_score;
  bit m_hit, m_pulse, m_drop;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int wrap16(input int x);
    logic signed [15:0] t;
    t = 16'(x);
    return int'(t);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_scroll[i] = 0; m_gap[i] = 0; m_valid[i] = 0; m_scored[i] = 0;
    end
    m_wr = 0; m_cnt = 0; m_score = 0;
    m_hit = 0; m_pulse = 0; m_drop = 0;
  endtask

  // advance the model by one clock using the inputs the DUT is about to sample
  task automatic model_step();
    int bs, bg, ns, pick;
    bit hit_n;
    int n_scroll [N];
    int n_gap    [N];
    bit n_valid  [N];
    bit n_scored [N];
    bs = bus.bird_scroll;
    bg = bus.bird_gap;
    hit_n = (bg <= GRND);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && (bs + BW > m_scroll[i]) && (bs < m_scroll[i] + PW) &&
          ((bg < m_gap[i]) || (bg + BH > m_gap[i] + GH)))
        hit_n = 1;
    if (bus.clear) begin
      model_reset();
    end else begin
      m_hit = hit_n;
      m_pulse = 0;
      if (bus.new_frame && bus.run) begin
        pick = -1;
        for (int i = 0; i < N; i++)
          if (pick < 0 && m_valid[i] && !m_scored[i] && (m_scroll[i] + PW < bs)) pick = i;
        n_scroll = m_scroll; n_gap = m_gap; n_valid = m_valid; n_scored = m_scored;
        for (int i = 0; i < N; i++)
          if (m_valid[i]) begin
            ns = wrap16(m_scroll[i] - SPEED);
            n_scroll[i] = ns;
            if (ns < OFFS) n_valid[i] = 0;
          end
        if (pick >= 0) begin
          n_scored[pick] = 1;
          if (m_score < 99) begin
            m_score++;
            m_pulse = 1;
          end
        end
        if (m_cnt == 0) begin
          if (!n_valid[m_wr]) begin
            n_scroll[m_wr] = SPOS;
            n_gap[m_wr]    = GBASE + int'(bus.rand_in);
            n_valid[m_wr]  = 1;
            n_scored[m_wr] = 0;
            m_wr = (m_wr + 1) % N;
          end else begin
            m_drop = 1;
          end
        end
        m_cnt = (m_cnt + 1) % PERIOD;
        m_scroll = n_scroll; m_gap = n_gap; m_valid = n_valid; m_scored = n_scored;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] es, eg, ev;
    es = '0; eg = '0; ev = '0;
    for (int i = 0; i < N; i++) begin
      es[16*i +: 16] = 16'(m_scroll[i]);
      eg[16*i +: 16] = 16'(m_gap[i]);
      ev[i] = m_valid[i];
    end
    chk("pipe_scroll", 64'(bus.pipe_scroll), es);
    chk("pipe_gap",    64'(bus.pipe_gap), eg);
    chk("pipe_valid",  64'(bus.pipe_valid), ev);
    chk("hit",         64'(bus.hit), 64'(m_hit));
    chk("score_pulse", 64'(bus.score_pulse), 64'(m_pulse));
    chk("score_bcd",   64'(bus.score_bcd), 64'({4'(m_score / 10), 4'(m_score % 10)}));
    chk("score_sat",   64'(bus.score_sat), 64'(m_score == 99));
    chk("spawn_drop",  64'(bus.spawn_drop), 64'(m_drop));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      bus.new_frame = 1'b1;
      step();
    end
    bus.new_frame = 1'b0;
  endtask

  initial begin
    bus.new_frame = 0; bus.run = 0; bus.clear = 0; bus.rand_in = 0;
    bus.bird_scroll = 0; bus.bird_gap = 16'sd50;
    bus2.new_frame = 0; bus2.run = 0; bus2.clear = 0; bus2.rand_in = 0;
    bus2.bird_scroll = -16'sd2000; bus2.bird_gap = 16'sd1000;
    rstn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  64'(bus.pipe_valid), 64'd0);
    chk("rst_scroll", 64'(bus.pipe_scroll), 64'd0);
    chk("rst_hit",    64'(bus.hit), 64'd0);
    chk("rst_bcd",    64'(bus.score_bcd), 64'd0);
    chk("rst_drop2",  64'(bus2.spawn_drop), 64'd0);
    rstn = 1'b1;

    // clear with a coincident frame strobe: clear wins
    bus.run = 1; bus.rand_in = 8'd37; bus.bird_scroll = 16'sd400; bus.bird_gap = 16'sd200;
    bus.clear = 1; bus.new_frame = 1;
    step();
    bus.clear = 0; bus.new_frame = 0;
    chk("clr_valid", 64'(bus.pipe_valid), 64'd0);

    frames(1);
    chk("spawn_valid",  64'(bus.pipe_valid), 64'b001);
    chk("spawn_scroll", 64'(bus.pipe_scroll[15:0]), 64'd640);
    chk("spawn_gap",    64'(bus.pipe_gap[15:0]), 64'd137);
    bus.rand_in = 8'd200;
    frames(10);
    chk("scroll_590", 64'(bus.pipe_scroll[15:0]), 64'd590);
    frames(42);
    chk("scroll_380", 64'(bus.pipe_scroll[15:0]), 64'd380);
    chk("no_spawn_yet", 64'(bus.pipe_valid), 64'b001);

    // collision against slot0 at 380 / gap 137..287
    bus.bird_gap = 16'sd200; step();
    chk("hit_in_gap", 64'(bus.hit), 64'd0);
    bus.bird_gap = 16'sd250; step();
    chk("hit_top_edge", 64'(bus.hit), 64'd1);
    bus.bird_gap = 16'sd247; step();
    chk("hit_top_flush", 64'(bus.hit), 64'd0);
    bus.bird_scroll = -16'sd2000;
    bus.bird_gap = 16'sd104; step();
    chk("hit_ground", 64'(bus.hit), 64'd1);
    bus.bird_gap = 16'sd105; step();
    chk("ground_clear", 64'(bus.hit), 64'd0);
    bus.bird_scroll = 16'sd400; bus.bird_gap = 16'sd200;

    frames(16);
    chk("scroll_300",    64'(bus.pipe_scroll[15:0]), 64'd300);
    chk("slot1_spawned", 64'(bus.pipe_valid), 64'b011);
    chk("score_pre",     64'(bus.score_bcd), 64'h00);
    frames(1);
    chk("pulse_first", 64'(bus.score_pulse), 64'd1);
    chk("score_01",    64'(bus.score_bcd), 64'h01);
    step();
    chk("pulse_single", 64'(bus.score_pulse), 64'd0);

    // two unscored pipes become candidates at once
    bus.bird_scroll = -16'sd2000;
    frames(70);
    chk("three_valid", 64'(bus.pipe_valid), 64'b111);
    bus.bird_scroll = 16'sd20000;
    frames(1);
    chk("dual_pulse_a", 64'(bus.score_pulse), 64'd1);
    chk("dual_score_a", 64'(bus.score_bcd), 64'h02);
    frames(1);
    chk("dual_pulse_b", 64'(bus.score_pulse), 64'd1);
    chk("dual_score_b", 64'(bus.score_bcd), 64'h03);
    frames(1);
    chk("dual_pulse_c", 64'(bus.score_pulse), 64'd0);
    chk("dual_score_c", 64'(bus.score_bcd), 64'h03);

    // slot0 reaches the off-screen limit
    bus.bird_scroll = -16'sd2000;
    frames(10);
    chk("scroll_m120", 64'(bus.pipe_scroll[15:0]), 64'(16'hFF88));
    chk("at_limit_valid", 64'(bus.pipe_valid[0]), 64'd1);
    frames(1);
    chk("retired", 64'(bus.pipe_valid[0]), 64'd0);
    chk("scroll_m125", 64'(bus.pipe_scroll[15:0]), 64'(16'hFF83));

    // randomized traffic
    for (int c = 0; c < 10000; c++) begin
      bus.new_frame = ($urandom_range(0, 3) != 0);
      bus.run       = ($urandom_range(0, 9) != 0);
      bus.clear     = ($urandom_range(0, 1999) == 0);
      bus.rand_in   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 6))
          0: bus.bird_scroll = 16'sd100;
          1: bus.bird_scroll = 16'sd300;
          2: bus.bird_scroll = 16'sd400;
          3: bus.bird_scroll = 16'sd700;
          4: bus.bird_scroll = 16'sd20000;
          5: bus.bird_scroll = -16'sd2000;
          default: bus.bird_scroll = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 7) == 0) bus.bird_gap = 16'($urandom);
      else bus.bird_gap = 16'($urandom_range(60, 420));
      step();
    end
    bus.clear = 0; bus.new_frame = 0; bus.run = 1;

    // long run to saturate the score
    bus.bird_scroll = 16'sd700; bus.bird_gap = 16'sd200;
    bus.clear = 1; step(); bus.clear = 0;
    for (int c = 0; c < 6600; c++) begin
      bus.rand_in = 8'($urandom_range(0, 255));
      frames(1);
    end
    chk("sat_bcd",  64'(bus.score_bcd), 64'h99);
    chk("sat_flag", 64'(bus.score_sat), 64'd1);

    // two slots, spawn every other frame, pipes never retire
    bus2.run = 1; bus2.rand_in = 8'd10;
    bus2.clear = 1; step(); bus2.clear = 0;
    chk("d2_clear", 64'(bus2.pipe_valid), 64'd0);
    bus2.new_frame = 1; step();
    bus2.rand_in = 8'd99;
    step(); step(); step();
    chk("d2_valid",   64'(bus2.pipe_valid), 64'b11);
    chk("d2_no_drop", 64'(bus2.spawn_drop), 64'd0);
    step();
    chk("d2_drop",      64'(bus2.spawn_drop), 64'd1);
    chk("d2_s0_scroll", 64'(bus2.pipe_scroll[15:0]), 64'd620);
    chk("d2_s0_gap",    64'(bus2.pipe_gap[15:0]), 64'd110);
    chk("d2_s1_gap",    64'(bus2.pipe_gap[31:16]), 64'd199);
    bus2.new_frame = 0; step();
    chk("d2_drop_sticky", 64'(bus2.spawn_drop), 64'd1);
    bus2.clear = 1; step(); bus2.clear = 0;
    chk("d2_drop_clr", 64'(bus2.spawn_drop), 64'd0);

    // asynchronous reset in the middle of a cycle
    bus.new_frame = 1;
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_valid",  64'(bus.pipe_valid), 64'd0);
    chk("arst_scroll", 64'(bus.pipe_scroll), 64'd0);
    chk("arst_gap",    64'(bus.pipe_gap), 64'd0);
    chk("arst_bcd",    64'(bus.score_bcd), 64'd0);
    chk("arst_sat",    64'(bus.score_sat), 64'd0);
    chk("arst_hit",    64'(bus.hit), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
